// File: rtl/crono_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crono_pkg : shared state encoding and clock constants for the stopwatch
// Rev 1.0
// ----------------------------------------------------------------------------
package crono_pkg;

  localparam int CLK_HZ        = 50000000;
  localparam int TICK_HZ       = 100;
  localparam int TICK_DIV_DFLT = CLK_HZ / TICK_HZ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } crono_state_t;

  function automatic logic is_counting(crono_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crono_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crono_ctrl_if : key inputs and datapath control outputs of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface crono_ctrl_if;

  logic       key0;
  logic       key1;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  modport master (
    input  key0, key1,
    output cnt_en, cnt_clr, lap_hold, running, state
  );

  modport slave (
    output key0, key1,
    input  cnt_en, cnt_clr, lap_hold, running, state
  );

endinterface
`default_nettype wire

// File: rtl/crono_ctrl_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_debounce : synchronise, debounce and edge-detect one raw push-button
// Rev 1.0
// ----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES     = 1000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int            CW         = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] C_DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          w_key_norm;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  assign w_key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= w_key_norm;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any single agreeing sample restarts the stability window.
      if (r_sync2 != r_level) begin
        if (r_cnt == C_DEB_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/crono_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crono_ctrl : stopwatch start/pause/lap/clear sequencer and centisecond tick
// Rev 1.0
// ----------------------------------------------------------------------------
module crono_ctrl
  import crono_pkg::*;
#(
  parameter int TICK_DIV       = TICK_DIV_DFLT,
  parameter int DEB_CYCLES     = 1000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  crono_ctrl_if.master bus
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] C_PRE_LAST = PW'(TICK_DIV - 1);

  crono_state_t  r_state;
  crono_state_t  w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic          r_cnt_en;
  logic          w_cnt_en_nxt;
  logic          r_cnt_clr;
  logic          w_cnt_clr_nxt;
  logic          r_lap_hold;
  logic          r_running;
  logic          w_ev0;
  logic          w_ev1;
  logic          w_lvl0;
  logic          w_lvl1;
  logic          w_cnt_now;
  logic          w_cnt_nxt;
  logic          w_unused;

  key_debounce #(
    .DEB_CYCLES     (DEB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_deb0 (
    .clk     (clk),
    .rst     (rst),
    .key_raw (bus.key0),
    .level   (w_lvl0),
    .press   (w_ev0)
  );

  key_debounce #(
    .DEB_CYCLES     (DEB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_deb1 (
    .clk     (clk),
    .rst     (rst),
    .key_raw (bus.key1),
    .level   (w_lvl1),
    .press   (w_ev1)
  );

  assign w_unused = w_lvl0 ^ w_lvl1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr_nxt = 1'b0;
    // key0 is tested first everywhere so it wins a same-cycle collision.
    case (r_state)
      IDLE: begin
        if (w_ev0) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_ev0)      w_state_nxt = PAUSE;
        else if (w_ev1) w_state_nxt = LAP;
      end
      LAP: begin
        if (w_ev0)      w_state_nxt = PAUSE;
        else if (w_ev1) w_state_nxt = RUN;
      end
      PAUSE: begin
        if (w_ev0) begin
          w_state_nxt = RUN;
        end else if (w_ev1) begin
          w_state_nxt   = IDLE;
          w_cnt_clr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_cnt_now    = is_counting(r_state);
    w_cnt_nxt    = is_counting(w_state_nxt);
    w_cnt_en_nxt = w_cnt_now && w_cnt_nxt && (r_pre == C_PRE_LAST);

    // Leaving RUN/LAP freezes the phase, so a tick due on that edge fires on resume.
    if (w_state_nxt == IDLE) begin
      w_pre_nxt = '0;
    end else if (w_cnt_now && w_cnt_nxt) begin
      w_pre_nxt = (r_pre == C_PRE_LAST) ? '0 : r_pre + PW'(1);
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pre      <= '0;
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b1;
      r_lap_hold <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre      <= w_pre_nxt;
      r_cnt_en   <= w_cnt_en_nxt;
      r_cnt_clr  <= w_cnt_clr_nxt;
      r_lap_hold <= (w_state_nxt == LAP);
      r_running  <= w_cnt_nxt;
    end
  end

  assign bus.cnt_en   = r_cnt_en;
  assign bus.cnt_clr  = r_cnt_clr;
  assign bus.lap_hold = r_lap_hold;
  assign bus.running  = r_running;
  assign bus.state    = r_state;

endmodule
`default_nettype wire
